uart_mmio_bridge: RTL and testbench

Memory-mapped UART bridge between the CPU data-memory port and the data-side RAM wrapper. It decodes two UART register addresses; every other access passes straight through to the RAM wrapper. Hits are served from internal RX/TX byte FIFOs, which it drains to and fills from the direct-serial `async_transmitter`/`async_receiver` pair. Software gets buffered, polled or interrupt-driven serial I/O without stalling the pipeline.

---
 rtl/uart_mmio_bridge.sv | 208 ++++++++++++++++++++
 tb/tb_uart_mmio_bridge.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio_bridge.sv
// CPU data-port bridge that maps a UART data/status register pair onto buffered RX/TX byte FIFOs.
// Optional registered RX interrupt output is built only when UART_RX_INT_EN is defined.
module uart_mmio_bridge #(
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter logic [31:0] UART_DATA_ADDR = 32'hBFD003F8,
  parameter logic [31:0] UART_STAT_ADDR = 32'hBFD003FC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ram_ce_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [3:0]  ram_sel_o,
  output logic [31:0] ram_data_o,
  input  logic [31:0] ram_data_i,
  input  logic        rx_ready_i,
  input  logic [7:0]  rx_data_i,
  input  logic        tx_busy_i,
  output logic        tx_start_o,
  output logic [7:0]  tx_data_o
`ifdef UART_RX_INT_EN
  ,
  output logic        uart_int_o
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    DRAIN = 2'd2
  } tx_state_t;

  // Address decode and access qualification
  logic hit_d, hit_s, hit;
  logic rd_data, wr_data, rd_stat;

  assign hit_d   = ce_i && (addr_i == UART_DATA_ADDR);
  assign hit_s   = ce_i && (addr_i == UART_STAT_ADDR);
  assign hit     = hit_d | hit_s;
  assign rd_data = hit_d & ~we_i;
  assign wr_data = hit_d & we_i & sel_i[0];
  assign rd_stat = hit_s & ~we_i;

  assign ram_ce_o   = ce_i & ~hit;
  assign ram_we_o   = we_i & ~hit;
  assign ram_addr_o = addr_i;
  assign ram_sel_o  = sel_i;
  assign ram_data_o = data_i;

  // RX FIFO
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [PW-1:0] rx_wr_ptr_reg, rx_wr_ptr_next;
  logic [PW-1:0] rx_rd_ptr_reg, rx_rd_ptr_next;
  logic [CW-1:0] rx_count_reg, rx_count_next;
  logic          rx_empty, rx_full, rx_push, rx_pop, rx_drop;
  logic [7:0]    rx_head;
  logic          overrun_reg, overrun_next;

  assign rx_empty = (rx_count_reg == '0);
  assign rx_full  = (rx_count_reg == DEPTH_C);
  assign rx_head  = rx_mem[rx_rd_ptr_reg];
  assign rx_pop   = rd_data & ~rx_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte
  assign rx_push  = rx_ready_i & (~rx_full | rx_pop);
  assign rx_drop  = rx_ready_i & rx_full & ~rx_pop;

  always_comb begin
    rx_wr_ptr_next = rx_wr_ptr_reg;
    rx_rd_ptr_next = rx_rd_ptr_reg;
    rx_count_next  = rx_count_reg;
    overrun_next   = overrun_reg;
    if (rx_push) rx_wr_ptr_next = rx_wr_ptr_reg + PTR_ONE;
    if (rx_pop)  rx_rd_ptr_next = rx_rd_ptr_reg + PTR_ONE;
    case ({rx_push, rx_pop})
      2'b10:   rx_count_next = rx_count_reg + CNT_ONE;
      2'b01:   rx_count_next = rx_count_reg - CNT_ONE;
      default: rx_count_next = rx_count_reg;
    endcase
    if (rx_drop)      overrun_next = 1'b1;
    else if (rd_stat) overrun_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr_reg] <= rx_data_i;
  end

  // TX FIFO
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wr_ptr_reg, tx_wr_ptr_next;
  logic [PW-1:0] tx_rd_ptr_reg, tx_rd_ptr_next;
  logic [CW-1:0] tx_count_reg, tx_count_next;
  logic          tx_empty, tx_full, tx_push, tx_pop;
  logic [7:0]    tx_head;

  assign tx_empty = (tx_count_reg == '0);
  assign tx_full  = (tx_count_reg == DEPTH_C);
  assign tx_head  = tx_mem[tx_rd_ptr_reg];
  assign tx_push  = wr_data & (~tx_full | tx_pop);

  always_comb begin
    tx_wr_ptr_next = tx_wr_ptr_reg;
    tx_rd_ptr_next = tx_rd_ptr_reg;
    tx_count_next  = tx_count_reg;
    if (tx_push) tx_wr_ptr_next = tx_wr_ptr_reg + PTR_ONE;
    if (tx_pop)  tx_rd_ptr_next = tx_rd_ptr_reg + PTR_ONE;
    case ({tx_push, tx_pop})
      2'b10:   tx_count_next = tx_count_reg + CNT_ONE;
      2'b01:   tx_count_next = tx_count_reg - CNT_ONE;
      default: tx_count_next = tx_count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr_reg] <= data_i[7:0];
  end

  // Transmit sequencer: issue one start, then wait out the transmitter's busy window
  tx_state_t  state_reg, state_next;
  logic       tx_start_reg, tx_start_next;
  logic [7:0] tx_data_reg, tx_data_next;

  always_comb begin
    state_next    = state_reg;
    tx_start_next = 1'b0;
    tx_data_next  = tx_data_reg;
    tx_pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!tx_empty && !tx_busy_i) begin
          tx_start_next = 1'b1;
          tx_data_next  = tx_head;
          tx_pop        = 1'b1;
          state_next    = ARM;
        end
      end
      ARM: begin
        if (tx_busy_i) state_next = DRAIN;
      end
      DRAIN: begin
        if (!tx_busy_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign tx_start_o = tx_start_reg;
  assign tx_data_o  = tx_data_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_wr_ptr_reg <= '0;
      rx_rd_ptr_reg <= '0;
      rx_count_reg  <= '0;
      overrun_reg   <= 1'b0;
      tx_wr_ptr_reg <= '0;
      tx_rd_ptr_reg <= '0;
      tx_count_reg  <= '0;
      state_reg     <= IDLE;
      tx_start_reg  <= 1'b0;
      tx_data_reg   <= '0;
    end else begin
      rx_wr_ptr_reg <= rx_wr_ptr_next;
      rx_rd_ptr_reg <= rx_rd_ptr_next;
      rx_count_reg  <= rx_count_next;
      overrun_reg   <= overrun_next;
      tx_wr_ptr_reg <= tx_wr_ptr_next;
      tx_rd_ptr_reg <= tx_rd_ptr_next;
      tx_count_reg  <= tx_count_next;
      state_reg     <= state_next;
      tx_start_reg  <= tx_start_next;
      tx_data_reg   <= tx_data_next;
    end
  end

  // Read data mux: register hits override the RAM return path
  always_comb begin
    data_o = ram_data_i;
    if (hit_s) begin
      data_o = {29'b0, overrun_reg, ~rx_empty, ~tx_full};
    end else if (hit_d) begin
      data_o = rx_empty ? 32'h0 : {24'b0, rx_head};
    end
  end

`ifdef UART_RX_INT_EN
  logic uart_int_reg;

  always_ff @(posedge clk) begin
    if (!rst) uart_int_reg <= 1'b0;
    else      uart_int_reg <= ~rx_empty | overrun_reg;
  end

  assign uart_int_o = uart_int_reg;
`endif

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Directed bench for uart_mmio_bridge: queue scoreboards for TX bytes and RX bytes, a
// simple transmitter busy model, and immediate-assertion checks at every comparison point.
module tb_uart_mmio_bridge;

  localparam logic [31:0] DATA_A = 32'hBFD003F8;
  localparam logic [31:0] STAT_A = 32'hBFD003FC;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce = 1'b0, we = 1'b0;
  logic [31:0] addr = '0;
  logic [3:0]  sel = 4'hF;
  logic [31:0] wdata = '0;
  logic [31:0] data_o;
  logic        ram_ce, ram_we;
  logic [31:0] ram_addr, ram_wdata;
  logic [3:0]  ram_sel;
  logic [31:0] ram_rdata = 32'hDEADBEEF;
  logic        rx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        busy = 1'b0;
  logic        tx_start;
  logic [7:0]  tx_data;
`ifdef UART_RX_INT_EN
  logic        uart_int;
`endif

  always #10 clk = ~clk;

  uart_mmio_bridge dut (
    .clk(clk), .rst(rst), .ce_i(ce), .we_i(we), .addr_i(addr), .sel_i(sel),
    .data_i(wdata), .data_o(data_o),
    .ram_ce_o(ram_ce), .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_sel_o(ram_sel),
    .ram_data_o(ram_wdata), .ram_data_i(ram_rdata),
    .rx_ready_i(rx_ready), .rx_data_i(rx_data), .tx_busy_i(busy),
    .tx_start_o(tx_start), .tx_data_o(tx_data)
`ifdef UART_RX_INT_EN
    , .uart_int_o(uart_int)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] tx_exp_q[$];
  logic [7:0] rx_exp_q[$];
  int   tx_starts = 0;
  logic tx_hold = 1'b0;
  int   busy_cnt = 0;
  logic ovr_m = 1'b0;
  logic tx_nf_m = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Transmitter model: busy for 10 cycles after each start, or held high on request
  always @(negedge clk) begin
    if (tx_start === 1'b1) begin
      tx_starts++;
      check("tx_start_while_busy", {31'b0, busy}, 32'h0);
      if (tx_exp_q.size() == 0) begin
        check("tx_unexpected_start", 32'h1, 32'h0 | {24'b0, tx_data} | 32'h1 ^ 32'h1);
      end else begin
        check("tx_byte", {24'b0, tx_data}, {24'b0, tx_exp_q.pop_front()});
      end
      if (!tx_hold) busy_cnt = 10;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    busy = tx_hold || (busy_cnt > 0);
    $display("tx monitor: start=%b data=%h busy=%b", tx_start, tx_data, busy);
  end

  function automatic logic [31:0] exp_stat();
    return {29'b0, ovr_m, rx_exp_q.size() != 0, tx_nf_m};
  endfunction

  task automatic cpu_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    ce = 1'b1; we = 1'b0; addr = a; sel = 4'hF;
    #1 d = data_o;
    @(posedge clk);
    #1 ce = 1'b0;
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    @(negedge clk);
    ce = 1'b1; we = 1'b1; addr = a; sel = s; wdata = d;
    @(posedge clk);
    #1 ce = 1'b0; we = 1'b0;
    $display("cpu write: addr=%h sel=%h data=%h", a, s, d);
  endtask

  task automatic stat_check(input string tag);
    logic [31:0] d;
    cpu_read(STAT_A, d);
    check(tag, d, exp_stat());
    if (d[2] === 1'b1 || ovr_m) ovr_m = 1'b0;
    $display("status read: %h", d);
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    @(negedge clk);
    rx_ready = 1'b1; rx_data = b;
    @(posedge clk);
    #1 rx_ready = 1'b0;
    if (rx_exp_q.size() < 16) rx_exp_q.push_back(b);
    else ovr_m = 1'b1;
    $display("rx pulse: %h", b);
  endtask

  task automatic rx_read_check(input string tag);
    logic [31:0] d;
    logic [31:0] e;
    e = (rx_exp_q.size() != 0) ? {24'b0, rx_exp_q.pop_front()} : 32'h0;
    cpu_read(DATA_A, d);
    check(tag, d, e);
    $display("data read: %h", d);
  endtask

  // Data read and rx_ready pulse landing on the same edge
  task automatic rx_read_with_push(input string tag, input logic [7:0] b);
    logic [31:0] d;
    logic [31:0] e;
    e = (rx_exp_q.size() != 0) ? {24'b0, rx_exp_q.pop_front()} : 32'h0;
    @(negedge clk);
    ce = 1'b1; we = 1'b0; addr = DATA_A; sel = 4'hF;
    rx_ready = 1'b1; rx_data = b;
    #1 d = data_o;
    check(tag, d, e);
    @(posedge clk);
    #1 ce = 1'b0; rx_ready = 1'b0;
    if (rx_exp_q.size() < 16) rx_exp_q.push_back(b);
    else ovr_m = 1'b1;
    $display("data read with rx push %h: %h", b, d);
  endtask

  initial begin
    // Reset
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    check("reset_tx_start", {31'b0, tx_start}, 32'h0);
`ifdef UART_RX_INT_EN
    check("reset_uart_int", {31'b0, uart_int}, 32'h0);
`endif
    stat_check("reset_status");

    // Pass-through and decode, all within one cycle so nothing reaches the FIFOs
    @(negedge clk);
    ce = 1'b1; we = 1'b0; addr = 32'h80000010; sel = 4'hF;
    #1;
    check("pt_ram_ce", {31'b0, ram_ce}, 32'h1);
    check("pt_read_data", data_o, 32'hDEADBEEF);
    check("pt_ram_addr", ram_addr, 32'h80000010);
    we = 1'b1; wdata = 32'h12345678; sel = 4'h3;
    #1;
    check("pt_ram_we", {31'b0, ram_we}, 32'h1);
    check("pt_ram_wdata", ram_wdata, 32'h12345678);
    check("pt_ram_sel", {28'b0, ram_sel}, 32'h3);
    we = 1'b0; addr = DATA_A; sel = 4'hF;
    #1;
    check("hit_ram_ce", {31'b0, ram_ce}, 32'h0);
    check("hit_empty_read", data_o, 32'h0);
    ce = 1'b0;

    // TX ordering with the busy model active
    for (int i = 0; i < 3; i++) begin
      tx_exp_q.push_back(8'h41 + 8'(i));
      cpu_write(DATA_A, 4'hF, 32'h41 + i);
      stat_check("tx_order_status");
    end
    for (int i = 0; i < 300 && tx_exp_q.size() != 0; i++) @(posedge clk);
    check("tx_order_drained", 32'(tx_exp_q.size()), 32'h0);
    check("tx_order_starts", 32'(tx_starts), 32'd3);
    repeat (20) @(posedge clk);

    // TX full with the transmitter held busy
    tx_hold = 1'b1;
    repeat (3) @(posedge clk);
    cpu_write(DATA_A, 4'b0010, 32'h99);
    for (int i = 0; i < 16; i++) begin
      tx_exp_q.push_back(8'h60 + 8'(i));
      cpu_write(DATA_A, 4'h1, 32'h60 + i);
      tx_nf_m = (i < 15);
      stat_check("tx_fill_status");
    end
    cpu_write(DATA_A, 4'h1, 32'h7F);
    stat_check("tx_overfill_status");

    // RX overrun
    for (int i = 0; i < 17; i++) rx_pulse(8'(i));
`ifdef UART_RX_INT_EN
    check("int_overrun", {31'b0, uart_int}, 32'h1);
`endif
    stat_check("rx_overrun_status");
    stat_check("rx_overrun_cleared");
    for (int i = 0; i < 16; i++) rx_read_check("rx_drain");
    rx_read_check("rx_empty_read");

    // Full RX: simultaneous pop and push keeps the count at 16 and sets no overrun
    for (int i = 0; i < 16; i++) rx_pulse(8'h20 + 8'(i));
    rx_read_with_push("rx_full_pushpop", 8'h55);
    stat_check("rx_full_pushpop_status");
    for (int i = 0; i < 16; i++) rx_read_check("rx_full_drain");
`ifdef UART_RX_INT_EN
    check("int_after_last_pop", {31'b0, uart_int}, 32'h1);
    @(posedge clk); #1;
    check("int_falls", {31'b0, uart_int}, 32'h0);
`endif
    rx_read_check("rx_after_full_drain");

    // Empty RX: simultaneous push lands, pop ignored
    rx_read_with_push("rx_empty_pushpop", 8'h66);
    rx_read_check("rx_empty_pushpop_data");
    rx_read_check("rx_empty_again");

    // Release the transmitter: exactly the 16 queued bytes go out
    tx_hold = 1'b0;
    for (int i = 0; i < 2000 && tx_exp_q.size() != 0; i++) @(posedge clk);
    check("tx_full_drained", 32'(tx_exp_q.size()), 32'h0);
    repeat (60) @(posedge clk);
    check("tx_total_starts", 32'(tx_starts), 32'd19);
    tx_nf_m = 1'b1;
    stat_check("final_status");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
